cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Execution controller for the single-cycle CPU on the board. It takes the three debounced push-button levels (step, run, halt) and sequences a one-cycle clock-enable to the CPU core. It supports halt, single-step and free-run at a divided rate, plus a PC breakpoint. It sits between the debounce stage and the CPU's clock-enable and PC outputs.

Parameters:
RUN_DIV, 25_000_000, clk cycles per instruction in RUN mode; legal range is 1 to 2^DIV_W-1.
DIV_W, 25, width of the run-rate divider counter.
PC_W, 32, width of the PC and breakpoint compare.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
btn_step  in  1  debounced step-button level, 1 = pressed.
btn_run  in  1  debounced run-button level, 1 = pressed.
btn_halt  in  1  debounced halt-button level, 1 = pressed.
cpu_halt_req  in  1  CPU has retired a halt instruction (level).
pc_in  in  PC_W  current CPU PC.
bp_addr  in  PC_W  breakpoint address.
bp_en  in  1  breakpoint enable.
cpu_ce  out  1  CPU clock-enable; one-cycle pulses, registered.
mode  out  2  current state: 0 HALT, 1 STEP, 2 RUN, 3 BREAK.
bp_hit  out  1  high while in BREAK.
instr_cnt  out  16  count of cpu_ce pulses; wraps.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=HALT; cpu_ce=0; bp_hit=0; instr_cnt=0; divider=0; skip_bp=0.
  - Edge-detect "previous" registers reset to 1, so a button held through reset does not produce a press.
- Press detection:
  - Each button is registered once (lvl), then prev<=lvl.
  - press = lvl & ~prev; exactly one press per 0→1 transition, whatever the hold length.
- Simultaneous presses in the same cycle: halt beats run, and run beats step.
- HALT:
  - step press → STEP.
  - run press → RUN, with divider cleared.
  - cpu_halt_req is ignored.
- STEP:
  - Lasts exactly one cycle, with cpu_ce=1 in that cycle.
  - Always returns to HALT.
  - No breakpoint or halt_req check is made; a step always executes.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - A tick occurs when divider==RUN_DIV-1; RUN_DIV=1 gives a tick every cycle.
  - On a tick with bp_en & pc_in==bp_addr & ~skip_bp: no cpu_ce; go to BREAK.
  - On any other tick: cpu_ce=1 for one cycle, and skip_bp<=0.
  - halt press or cpu_halt_req=1 → HALT, with divider cleared and no cpu_ce that cycle, even if it is a tick cycle.
- BREAK:
  - bp_hit=1.
  - step press → STEP.
  - run press → RUN with skip_bp<=1, so the first tick executes the breakpoint instruction.
  - halt press → HALT, with bp_hit cleared.
- cpu_ce timing:
  - cpu_ce is driven from a register asserted on the edge that enters STEP (or on the tick edge in RUN).
  - Latency: btn_step first sampled high at edge E0 → cpu_ce high from E1 to E2.
- instr_cnt increments on the edge where cpu_ce is asserted and wraps 0xFFFF→0x0000.
- Output encodings:
  - mode is a registered copy of state.
  - bp_hit = (state==BREAK).
- Reset mid-RUN takes effect at the next edge: cpu_ce drops, instr_cnt returns to 0.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (HALT=2'd0, STEP=2'd1, RUN=2'd2, BREAK=2'd3), also used as the mode encoding;
  - CNT_W=16.
- Sub-module btn_edge: a one-bit level register plus rising-edge pulse, with reset prev=1. It is instantiated three times.
- The FSM, divider and counter live in cpu_run_ctrl.

Test Plan:
1. Reset with btn_step held high, then release and press once (hold 100 cycles) → no pulse during reset or hold-over; exactly one cpu_ce pulse, 1 cycle after sampling; instr_cnt=1; mode back to 0.
2. RUN_DIV=4: press run, wait 40 cycles → cpu_ce pulses every 4th cycle (10 pulses); press halt → mode=0 and no further pulses.
3. RUN_DIV=4, bp_en=1, bp_addr=0x0000_0010, model PC += 4 per ce starting at 0:
   - run → four pulses, then BREAK with mode=3, bp_hit=1, pc=0x10;
   - press run → next tick pulses, pc goes to 0x14, bp_hit=0.
4. Same clock edge: btn_halt and btn_run both rise while in RUN → HALT; step+run together from HALT → RUN.
5. RUN_DIV=1, cpu_halt_req asserted after 5 pulses → exactly 5 cpu_ce pulses; mode=0; a step press still produces 1 pulse.
6. Preload instr_cnt to 0xFFFE via 65534 steps at RUN_DIV=1, then 2 more → wraps to 0x0000; assert rst_n=0 mid-RUN → cpu_ce=0 and instr_cnt=0 the next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state (doubles as the mode code)
// and the instruction counter width.
package cpu_ctrl_pkg;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        STEP  = 2'd1,
        RUN   = 2'd2,
        BREAK = 2'd3
    } state_t;
endpackage

// File: rtl/btn_edge.sv
// Registers a debounced button level and emits a one-cycle pulse on each 0->1 transition.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    logic lvl;
    logic prev;

    // Both stages reset high so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl  <= 1'b1;
            prev <= 1'b1;
        end else begin
            lvl  <= btn;
            prev <= lvl;
        end
    end

    assign press = lvl & ~prev;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller: turns step/run/halt presses into one-cycle CPU clock-enables,
// with a divided free-run rate and a PC breakpoint.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 25_000_000,
    parameter int DIV_W   = 25,
    parameter int PC_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             btn_halt,
    input  logic             cpu_halt_req,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_en,
    output logic             cpu_ce,
    output logic [1:0]       mode,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt
);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             skip_bp;
    logic             step_p, run_p, halt_p;
    logic             tick, bp_match;

    btn_edge u_step (.clk(clk), .rst_n(rst_n), .btn(btn_step), .press(step_p));
    btn_edge u_run  (.clk(clk), .rst_n(rst_n), .btn(btn_run),  .press(run_p));
    btn_edge u_halt (.clk(clk), .rst_n(rst_n), .btn(btn_halt), .press(halt_p));

    assign tick     = (div == DIV_MAX);
    // skip_bp lets the instruction sitting on the breakpoint retire after a resume.
    assign bp_match = bp_en & (pc_in == bp_addr) & ~skip_bp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HALT;
            cpu_ce    <= 1'b0;
            instr_cnt <= '0;
            div       <= '0;
            skip_bp   <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                HALT: begin
                    if (!halt_p) begin
                        if (run_p) begin
                            state <= RUN;
                            div   <= '0;
                        end else if (step_p) begin
                            state     <= STEP;
                            cpu_ce    <= 1'b1;
                            instr_cnt <= instr_cnt + 1'b1;
                        end
                    end
                end
                STEP: state <= HALT;
                RUN: begin
                    if (halt_p || cpu_halt_req) begin
                        state <= HALT;
                        div   <= '0;
                    end else if (tick) begin
                        div <= '0;
                        if (bp_match) begin
                            state <= BREAK;
                        end else begin
                            cpu_ce    <= 1'b1;
                            instr_cnt <= instr_cnt + 1'b1;
                            skip_bp   <= 1'b0;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                BREAK: begin
                    if (halt_p) begin
                        state <= HALT;
                    end else if (run_p) begin
                        state   <= RUN;
                        div     <= '0;
                        skip_bp <= 1'b1;
                    end else if (step_p) begin
                        state     <= STEP;
                        cpu_ce    <= 1'b1;
                        instr_cnt <= instr_cnt + 1'b1;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    assign mode   = state;
    assign bp_hit = (state == BREAK);
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: one instance at RUN_DIV=4, one at RUN_DIV=1, shared stimulus.
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_step = 1'b0, btn_run = 1'b0, btn_halt = 1'b0;
    logic        cpu_halt_req = 1'b0, bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc_in;

    logic        ce4, ce1, bp4, bp1;
    logic [1:0]  mode4, mode1;
    logic [15:0] ic4, ic1;

    int nvec = 0, nmis = 0;
    int cnt4 = 0, cnt1 = 0;
    int pc_base = 0, s = 0;

    always #5 clk = ~clk;

    // Pulse counters, sampled well after the rising edge.
    always @(posedge clk) begin
        #2;
        if (ce4) cnt4++;
        if (ce1) cnt1++;
    end

    // CPU model: PC advances by 4 per executed instruction of the RUN_DIV=4 instance.
    assign pc_in = 32'((cnt4 - pc_base) * 4);

    cpu_run_ctrl #(.RUN_DIV(4), .DIV_W(25), .PC_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run),
        .btn_halt(btn_halt), .cpu_halt_req(cpu_halt_req), .pc_in(pc_in),
        .bp_addr(bp_addr), .bp_en(bp_en), .cpu_ce(ce4), .mode(mode4),
        .bp_hit(bp4), .instr_cnt(ic4)
    );

    cpu_run_ctrl #(.RUN_DIV(1), .DIV_W(25), .PC_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run),
        .btn_halt(btn_halt), .cpu_halt_req(cpu_halt_req), .pc_in(pc_in),
        .bp_addr(bp_addr), .bp_en(bp_en), .cpu_ce(ce1), .mode(mode1),
        .bp_hit(bp1), .instr_cnt(ic1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        // 1: step held through reset, then a single clean press
        btn_step = 1'b1;
        cyc(3);
        chk("rst ce", 32'(ce4), 0);
        chk("rst mode", 32'(mode4), 0);
        chk("rst bp_hit", 32'(bp4), 0);
        chk("rst bp_hit1", 32'(bp1), 0);
        chk("rst icnt", 32'(ic4), 0);
        rst_n = 1'b1;
        cyc(5);
        chk("holdover pulses", 32'(cnt4), 0);
        btn_step = 1'b0;
        cyc(3);
        s = cnt4;
        btn_step = 1'b1;
        cyc(1);
        chk("step E0 ce", 32'(ce4), 0);
        cyc(1);
        chk("step E1 ce", 32'(ce4), 1);
        chk("step E1 mode", 32'(mode4), 1);
        cyc(1);
        chk("step E2 ce", 32'(ce4), 0);
        chk("step mode back", 32'(mode4), 0);
        chk("step icnt", 32'(ic4), 1);
        cyc(100);
        chk("step long hold", 32'(cnt4 - s), 1);
        btn_step = 1'b0;
        cyc(2);

        // 2: free run at RUN_DIV=4, then halt landing on a tick edge
        do_reset;
        s = cnt4;
        btn_run = 1'b1;
        cyc(2);
        chk("run mode", 32'(mode4), 2);
        cyc(42);
        chk("run 10 pulses", 32'(cnt4 - s), 10);
        btn_run = 1'b0;
        btn_halt = 1'b1;
        s = cnt4;
        cyc(2);
        chk("halt mode", 32'(mode4), 0);
        cyc(20);
        chk("halt no pulses", 32'(cnt4 - s), 0);
        btn_halt = 1'b0;
        cyc(2);

        // 3: breakpoint at 0x10, then resume past it
        do_reset;
        bp_en = 1'b1;
        bp_addr = 32'h10;
        pc_base = cnt4;
        btn_run = 1'b1;
        cyc(30);
        chk("bp pulses", 32'(cnt4 - pc_base), 4);
        chk("bp mode", 32'(mode4), 3);
        chk("bp hit", 32'(bp4), 1);
        chk("bp pc", pc_in, 32'h10);
        chk("bp icnt", 32'(ic4), 4);
        btn_run = 1'b0;
        cyc(2);
        s = cnt4;
        btn_run = 1'b1;
        cyc(2);
        chk("resume mode", 32'(mode4), 2);
        chk("resume bp_hit", 32'(bp4), 0);
        cyc(5);
        chk("resume pulse", 32'(cnt4 - s), 1);
        chk("resume pc", pc_in, 32'h14);
        btn_run = 1'b0;
        btn_halt = 1'b1;
        cyc(3);
        chk("bp halt mode", 32'(mode4), 0);
        btn_halt = 1'b0;
        bp_en = 1'b0;
        cyc(2);

        // 4: simultaneous presses
        do_reset;
        btn_run = 1'b1;
        cyc(3);
        chk("pri run", 32'(mode4), 2);
        btn_run = 1'b0;
        cyc(2);
        btn_run = 1'b1;
        btn_halt = 1'b1;
        cyc(2);
        chk("pri halt>run in RUN", 32'(mode4), 0);
        btn_run = 1'b0;
        btn_halt = 1'b0;
        cyc(2);
        btn_run = 1'b1;
        btn_halt = 1'b1;
        cyc(3);
        chk("pri halt>run in HALT", 32'(mode4), 0);
        btn_run = 1'b0;
        btn_halt = 1'b0;
        cyc(2);
        s = cnt4;
        btn_step = 1'b1;
        btn_run = 1'b1;
        cyc(2);
        chk("pri run>step mode", 32'(mode4), 2);
        chk("pri run>step no ce", 32'(cnt4 - s), 0);
        btn_step = 1'b0;
        btn_run = 1'b0;
        btn_halt = 1'b1;
        cyc(3);
        btn_halt = 1'b0;
        cyc(1);

        // 5: RUN_DIV=1 stopped by cpu_halt_req after 5 instructions
        do_reset;
        s = cnt1;
        btn_run = 1'b1;
        cyc(7);
        cpu_halt_req = 1'b1;
        cyc(5);
        chk("hreq pulses", 32'(cnt1 - s), 5);
        chk("hreq mode", 32'(mode1), 0);
        btn_run = 1'b0;
        cyc(1);
        s = cnt1;
        btn_step = 1'b1;
        cyc(3);
        btn_step = 1'b0;
        chk("hreq step pulse", 32'(cnt1 - s), 1);
        chk("hreq icnt", 32'(ic1), 6);
        cpu_halt_req = 1'b0;
        cyc(2);

        // 6: counter wrap, then reset in the middle of RUN
        do_reset;
        btn_run = 1'b1;
        cyc(65536);
        cpu_halt_req = 1'b1;
        btn_run = 1'b0;
        cyc(3);
        chk("wrap preload", 32'(ic1), 32'hFFFE);
        chk("wrap mode", 32'(mode1), 0);
        cpu_halt_req = 1'b0;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            btn_step = 1'b1;
            cyc(3);
            btn_step = 1'b0;
            cyc(2);
            chk("wrap step", 32'(ic1), (i == 0) ? 32'hFFFF : 32'h0);
        end
        btn_run = 1'b1;
        cyc(6);
        chk("midrun ce", 32'(ce1), 1);
        chk("midrun mode", 32'(mode1), 2);
        rst_n = 1'b0;
        cyc(1);
        chk("midrun rst ce", 32'(ce1), 0);
        chk("midrun rst icnt", 32'(ic1), 0);
        chk("midrun rst mode", 32'(mode1), 0);
        btn_run = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
